// File: rtl/io_pkg.sv
// Shared constants, state encoding and the saturating-step helper for the
// io_control sequencer and its cursor sub-module.
package io_pkg;

  localparam int CANVAS_X0 = 86;
  localparam int CANVAS_Y0 = 36;
  localparam int CANVAS_W  = 145;
  localparam int CANVAS_H  = 193;
  localparam int BRUSH_W   = 11;
  localparam int BRUSH_H   = 15;
  localparam int STEP      = 1;

  // The cursor is the brush's top-left corner, so the brush must still fit
  // inside the canvas at the far bounds.
  localparam logic [7:0] X_MIN  = 8'(CANVAS_X0);
  localparam logic [7:0] X_MAX  = 8'(CANVAS_X0 + CANVAS_W - BRUSH_W);
  localparam logic [7:0] Y_MIN  = 8'(CANVAS_Y0);
  localparam logic [7:0] Y_MAX  = 8'(CANVAS_Y0 + CANVAS_H - BRUSH_H);
  localparam logic [7:0] STEP_W = 8'(STEP);

  localparam logic [14:0] DRAW_LEN  = 15'(BRUSH_W * BRUSH_H);
  localparam logic [14:0] CLEAR_LEN = 15'(CANVAS_W * CANVAS_H);

  localparam logic [2:0] COLOUR_INK = 3'b111;
  localparam logic [2:0] COLOUR_BG  = 3'b000;

  typedef enum logic [1:0] {
    S_RESET,
    S_CLEAR,
    S_IDLE,
    S_DRAW
  } state_t;

  // Opposing pulses cancel; a single pulse moves one STEP and clamps at the bound.
  function automatic logic [7:0] step_pos(input logic [7:0] pos,
                                          input logic       dec,
                                          input logic       inc,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic [7:0] res;
    res = pos;
    if (dec && !inc) begin
      res = (pos >= lo + STEP_W) ? pos - STEP_W : lo;
    end else if (inc && !dec) begin
      res = (pos + STEP_W <= hi) ? pos + STEP_W : hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/io_cursor.sv
// Brush cursor position registers; moves only when enabled, saturating at the
// canvas bounds so the brush never leaves the canvas.
module io_cursor
  import io_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic       mv_left,
  input  logic       mv_right,
  output logic [7:0] x_cur,
  output logic [7:0] y_cur
);

  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (enable) begin
      x_d = step_pos(x_q, mv_left, mv_right, X_MIN, X_MAX);
      y_d = step_pos(y_q, mv_up, mv_down, Y_MIN, Y_MAX);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= X_MIN;
      y_q <= Y_MIN;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_cur = x_q;
  assign y_cur = y_q;

endmodule

// File: rtl/io_control.sv
// Upstream sequencer for io_datapath: turns key pulses into timed draw/erase
// bursts and clears the whole canvas after every reset.
module io_control
  import io_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       draw_req,
  input  logic       clear_req,
  output logic [7:0] x_cur,
  output logic [7:0] y_cur,
  output logic       draw,
  output logic       erase,
  output logic       count_reset,
  output logic       plot,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        move_en;

  // Moves only land in idle when no burst request wins the same cycle.
  assign move_en = (state_q == S_IDLE) && !clear_req && !draw_req;

  io_cursor u_cursor (
    .clock    (clock),
    .reset    (reset),
    .enable   (move_en),
    .mv_up    (mv_up),
    .mv_down  (mv_down),
    .mv_left  (mv_left),
    .mv_right (mv_right),
    .x_cur    (x_cur),
    .y_cur    (y_cur)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_RESET: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
      S_CLEAR: begin
        if (cnt_q == CLEAR_LEN - 15'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (clear_req) begin
          state_d = S_CLEAR;
        end else if (draw_req) begin
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (cnt_q == DRAW_LEN - 15'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs come from registers only, so requests never reach them combinationally.
  always_comb begin
    draw        = 1'b0;
    erase       = 1'b0;
    plot        = 1'b0;
    count_reset = 1'b0;
    colour      = COLOUR_BG;
    busy        = 1'b1;
    unique case (state_q)
      S_CLEAR: begin
        erase       = 1'b1;
        plot        = 1'b1;
        count_reset = 1'b1;
      end
      S_IDLE: begin
        busy = 1'b0;
      end
      S_DRAW: begin
        draw        = 1'b1;
        plot        = 1'b1;
        count_reset = 1'b1;
        colour      = COLOUR_INK;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign done = done_q;

endmodule
